// File: rtl/occ_table_responder.sv
// Occ table AXI4-Lite slave: 256-bit blocks held in a dual-port RAM, reads answered
// in order through a small response FIFO, writes committed from AW/W holding registers.
module occ_table_responder #(
   parameter int unsigned   AW       = 40,
   parameter logic [AW-1:0] OCC_BASE = 40'h00_0000_0000,
   parameter int unsigned   IDX_W    = 12,
   parameter int unsigned   RD_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] s_axi_occ_awaddr_i,
   input  logic [2:0]    s_axi_occ_awprot_i,
   input  logic          s_axi_occ_awvalid_i,
   output logic          s_axi_occ_awready_o,
   input  logic [255:0]  s_axi_occ_wdata_i,
   input  logic [31:0]   s_axi_occ_wstrb_i,
   input  logic          s_axi_occ_wvalid_i,
   output logic          s_axi_occ_wready_o,
   output logic [1:0]    s_axi_occ_bresp_o,
   output logic          s_axi_occ_bvalid_o,
   input  logic          s_axi_occ_bready_i,
   input  logic [AW-1:0] s_axi_occ_araddr_i,
   input  logic [2:0]    s_axi_occ_arprot_i,
   input  logic          s_axi_occ_arvalid_i,
   output logic          s_axi_occ_arready_o,
   output logic [255:0]  s_axi_occ_rdata_o,
   output logic [1:0]    s_axi_occ_rresp_o,
   output logic          s_axi_occ_rvalid_o,
   input  logic          s_axi_occ_rready_i
);

   typedef enum logic [1:0] { RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10 } resp_e;

   localparam int unsigned   PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
   localparam int unsigned   CW = $clog2(RD_DEPTH + 1);
   localparam int unsigned   OW = CW + 1;
   localparam logic [AW-1:0] WIN_MASK = ~((AW'(1) << (IDX_W + 5)) - AW'(1));

   function automatic logic win_hit(input logic [AW-1:0] addr);
      return (addr & WIN_MASK) == OCC_BASE;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RD_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [255:0]     mem [2**IDX_W];
   logic [255:0]     fifo_data_q [RD_DEPTH];
   resp_e            fifo_resp_q [RD_DEPTH];
   logic [255:0]     rd_data_q;

   logic             rd_pend_q, rd_pend_d, rd_hit_q, rd_hit_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             aw_v_q, aw_v_d, w_v_q, w_v_d, bvalid_q, bvalid_d;
   logic [AW-1:0]    aw_addr_q, aw_addr_d;
   logic [255:0]     w_data_q, w_data_d;
   logic [31:0]      w_strb_q, w_strb_d;
   resp_e            bresp_q, bresp_d;

   logic             ar_hs, aw_hs, w_hs, r_pop, b_pop, commit, aw_hit_q, wr_en;
   logic [OW-1:0]    occupancy;
   logic [IDX_W-1:0] ar_idx, aw_idx;
   logic             unused_ok;

   assign unused_ok = ^{s_axi_occ_awprot_i, s_axi_occ_arprot_i, aw_addr_q[4:0]};

   // Read-side occupancy counts the RAM stage too, so arready ignores rready.
   assign occupancy           = {1'b0, cnt_q} + OW'(rd_pend_q);
   assign s_axi_occ_arready_o = !rst && (occupancy < OW'(RD_DEPTH));
   assign s_axi_occ_rvalid_o  = !rst && (cnt_q != '0);
   assign s_axi_occ_rdata_o   = s_axi_occ_rvalid_o ? fifo_data_q[rd_ptr_q] : '0;
   assign s_axi_occ_rresp_o   = s_axi_occ_rvalid_o ? fifo_resp_q[rd_ptr_q] : RESP_OKAY;

   assign s_axi_occ_awready_o = !rst && !aw_v_q;
   assign s_axi_occ_wready_o  = !rst && !w_v_q;
   assign s_axi_occ_bvalid_o  = !rst && bvalid_q;
   assign s_axi_occ_bresp_o   = s_axi_occ_bvalid_o ? bresp_q : RESP_OKAY;

   assign ar_hs    = s_axi_occ_arvalid_i && s_axi_occ_arready_o;
   assign aw_hs    = s_axi_occ_awvalid_i && s_axi_occ_awready_o;
   assign w_hs     = s_axi_occ_wvalid_i && s_axi_occ_wready_o;
   assign r_pop    = s_axi_occ_rvalid_o && s_axi_occ_rready_i;
   assign b_pop    = s_axi_occ_bvalid_o && s_axi_occ_bready_i;
   assign commit   = aw_v_q && w_v_q && !bvalid_q;
   assign aw_hit_q = win_hit(aw_addr_q);
   assign wr_en    = commit && aw_hit_q && !rst;
   assign ar_idx   = s_axi_occ_araddr_i[IDX_W+4:5];
   assign aw_idx   = aw_addr_q[IDX_W+4:5];

   always_comb begin
      rd_pend_d = ar_hs;
      rd_hit_d  = win_hit(s_axi_occ_araddr_i);
      wr_ptr_d  = rd_pend_q ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = r_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
      cnt_d     = cnt_q;
      if (rd_pend_q && !r_pop)      cnt_d = cnt_q + CW'(1);
      else if (!rd_pend_q && r_pop) cnt_d = cnt_q - CW'(1);

      aw_v_d    = aw_v_q;
      aw_addr_d = aw_addr_q;
      w_v_d     = w_v_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (commit) begin
         aw_v_d   = 1'b0;
         w_v_d    = 1'b0;
         bvalid_d = 1'b1;
         bresp_d  = aw_hit_q ? RESP_OKAY : RESP_SLVERR;
      end else if (b_pop) begin
         bvalid_d = 1'b0;
      end
      if (aw_hs) begin
         aw_v_d    = 1'b1;
         aw_addr_d = s_axi_occ_awaddr_i;
      end
      if (w_hs) begin
         w_v_d    = 1'b1;
         w_data_d = s_axi_occ_wdata_i;
         w_strb_d = s_axi_occ_wstrb_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q <= 1'b0;
         rd_hit_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         aw_v_q    <= 1'b0;
         aw_addr_q <= '0;
         w_v_q     <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_hit_q  <= rd_hit_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         aw_v_q    <= aw_v_d;
         aw_addr_q <= aw_addr_d;
         w_v_q     <= w_v_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Both ports use non-blocking updates, so a same-index read sees the old word.
   always_ff @(posedge clk) begin
      if (ar_hs) rd_data_q <= mem[ar_idx];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < 32; i++) begin
            if (w_strb_q[i]) mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rd_pend_q) begin
         fifo_data_q[wr_ptr_q] <= rd_hit_q ? rd_data_q : '0;
         fifo_resp_q[wr_ptr_q] <= rd_hit_q ? RESP_OKAY : RESP_SLVERR;
      end
   end

endmodule
